seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Runtime-programmable serial pattern detector; the parametrised successor to the fixed-pattern Moore sequence detectors in the sequential-logic set. It samples a 1-bit serial stream under a valid qualifier and compares it against a loadable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping detection is selectable, and it keeps a saturating hit counter. Out of reset it behaves as a 1010 overlapping detector, with a registered (Moore-style) match output.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LW, $clog2(MAX_LEN)+1: width of the length field (derived; do not override).
- CNT_W, 8: width of the hit counter.
- RST_PAT, 8'b0000_1010: pattern loaded at reset (MAX_LEN bits, right-aligned).
- RST_LEN, 4: pattern length loaded at reset.
- RST_OVL, 1: overlap mode loaded at reset.
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only in cycles where this is 1.
- cfg_load  in  1  load pattern, length and mode; restart detection.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first bit expected.
- cfg_len  in  LW  new pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count.
- y  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating number of matches.

## Operation
- **Stored registers:** pat_q, len_q, ovl_q, history hist_q[MAX_LEN-1:0], fill counter fill_q (0..MAX_LEN), y, match_count.
- **Reset:**
  - pat_q=RST_PAT, len_q=RST_LEN, ovl_q=RST_OVL.
  - hist_q=0, fill_q=0, y=0, match_count=0.
- **Accepted sample** (x_valid=1, cfg_load=0):
  - hist_q shifts left with x entering bit 0.
  - fill_q increments, saturating at MAX_LEN.
- **Match condition:** evaluated on the post-shift history.
  - Requires fill'≥len_q.
  - Requires hist'[len_q-1:0]==pat_q[len_q-1:0].
- **On a match:**
  - y is set for the next cycle.
  - match_count increments.
  - If ovl_q=0, fill_q is forced to 0. History bits are kept but ignored until refilled.
  - If ovl_q=1, fill_q is unchanged, so a suffix can start the next match.
- **Length rules:**
  - len_q=0 disables detection: y is never set.
  - A cfg_len greater than MAX_LEN is clamped to MAX_LEN at load.
- **cfg_load=1:**
  - Latches pattern, length (clamped) and mode.
  - Clears hist_q and fill_q; y=0 next cycle.
  - The x sample in that cycle is discarded.
  - match_count is unaffected.
- **cnt_clr=1:** match_count=0 next cycle; clear wins over a simultaneous increment.
- **Saturation:** match_count saturates at 2^CNT_W-1; no wrap.
- **Idle cycles** (x_valid=0): state holds; y=0 next cycle.

## Timing
- Latency: y rises in the cycle after the rising edge that sampled the completing bit. It is high for exactly one cycle per match.
- In overlap mode, back-to-back matches give a y high on consecutive cycles. Example: pattern 11, continuous 1s.
- match_count updates on the same edge that sets y.
- Asynchronous reset mid-stream immediately forces all reset values, including discarding a partially collected pattern. The first sample after rst deassert is taken on the first rising edge with x_valid=1.
- cfg_load together with cnt_clr: both take effect on the same edge.

## Configuration
- SEQ_DET_HIT_CNT_EN:
  - Defined: match_count and cnt_clr are implemented as described.
  - Undefined: no counter flops are synthesised, match_count is tied to 0, and cnt_clr is ignored. y behaviour is identical in both builds.

## Test plan
- **Reset defaults:** rst pulse, then stream 1,0,1,0,1,0 with x_valid=1 → y pulses after the 4th and 6th samples; match_count=2.
- **Non-overlap:** cfg_load with pattern 1010, len 4, overlap 0, then the same stream → one y pulse after the 4th sample; match_count=1.
- **Gaps:** stream 1,_,0,_,_,1,0, where _ is x_valid=0 → exactly one y pulse, one cycle after the last 0. No pulse during gaps.
- **Mid-pattern reload:** after 1,0,1, cfg_load pattern 111, len 3, overlap 1, then five 1s → y high on the 3rd, 4th and 5th post-sample cycles. cfg_len=0 → no pulses. cfg_len=15 → len_q=8.
- **Counter boundaries:** CNT_W=2, seven matches → match_count stops at 3. cnt_clr coincident with a match → 0. Without SEQ_DET_HIT_CNT_EN → match_count is always 0.
- **Reset mid-operation:** assert rst after 1,0,1 → y=0 and match_count=0 immediately. Then 0 alone → no match. Full 1,0,1,0 → match.

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// Bus bundle for seq_detect_prog: serial sample stream, configuration load,
// counter clear and the detector outputs.
//
// Qualifier semantics: x is consumed on a rising clock edge only when
// x_valid=1 and cfg_load=0; there is no back-pressure, so the detector
// accepts every qualified sample. cfg_load and cnt_clr are single-cycle
// commands that act on the edge where they are seen high. y is a
// registered one-cycle pulse.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LW = $clog2(MAX_LEN) + 1;

  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               y;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  y, match_count
  );

  modport slave (
    input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output y, match_count
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector.
// Compares the most recent len_q accepted bits against pat_q[len_q-1:0]
// (bit len_q-1 is the oldest / first expected). Overlapping or
// non-overlapping detection is chosen by ovl_q. y is a registered pulse.
// Build option: define SEQ_DET_HIT_CNT_EN to implement the saturating hit
// counter (match_count / cnt_clr); otherwise match_count is tied to zero.
module seq_detect_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0000_1010,
  parameter int                 RST_LEN = 4,
  parameter bit                 RST_OVL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seq_detect_prog_if.slave  bus
);
  localparam int            LW     = $clog2(MAX_LEN) + 1;
  localparam logic [LW-1:0] LEN_MX = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               y_q, y_d;

  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_inc;
  logic               pat_eq;
  logic               hit;

  // Next-state: config load, sample shift, match evaluation on post-shift history
  always_comb begin
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    hit      = 1'b0;
    hist_sh  = {hist_q[MAX_LEN-2:0], bus.x};
    fill_inc = (fill_q == LEN_MX) ? fill_q : fill_q + 1'b1;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
    pat_eq = (((hist_sh ^ pat_q) & len_mask) == '0);

    if (bus.cfg_load) begin
      // The sample in a load cycle is dropped and detection restarts.
      pat_d  = bus.cfg_pattern;
      len_d  = (bus.cfg_len > LEN_MX) ? LEN_MX : bus.cfg_len;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.x_valid) begin
      hist_d = hist_sh;
      fill_d = fill_inc;
      // len_q==0 disables detection entirely.
      if ((len_q != '0) && (fill_inc >= len_q) && pat_eq) begin
        hit = 1'b1;
        // Non-overlap: stale history stays but is ignored until refilled.
        if (!ovl_q) fill_d = '0;
      end
    end
    y_d = hit;
  end

  // State registers with asynchronous reset to the default 1010 detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      len_q  <= LW'(RST_LEN);
      ovl_q  <= RST_OVL;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  assign bus.y = y_q;

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating hit counter; clear takes priority over a coincident hit
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr  = bus.cnt_clr;
  assign bus.match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: two instances share one stimulus stream, one
// with an 8-bit counter and one with a 2-bit counter (saturation). A queue
// model of the accepted bit stream predicts every y pulse and the counts.
module tb_seq_detect_prog;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef SEQ_DET_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus_a ();
  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus_b ();

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Expected {count_b[1:0], count_a[7:0]} after each predicted match edge
  logic [9:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_bits[$];   // accepted bits since last restart, newest at back
  int         m_ca, m_cb;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b0000_1010;
    m_len = 4;
    m_ovl = 1'b1;
    m_bits.delete();
    m_ca = 0;
    m_cb = 0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    bus_a.x = 1'b0; bus_a.x_valid = 1'b0; bus_a.cfg_load = 1'b0;
    bus_a.cfg_pattern = '0; bus_a.cfg_len = '0; bus_a.cfg_overlap = 1'b0; bus_a.cnt_clr = 1'b0;
    bus_b.x = 1'b0; bus_b.x_valid = 1'b0; bus_b.cfg_load = 1'b0;
    bus_b.cfg_pattern = '0; bus_b.cfg_len = '0; bus_b.cfg_overlap = 1'b0; bus_b.cnt_clr = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit xb, input bit v, input bit ld, input logic [7:0] pat,
                      input int len, input bit ovl, input bit clr);
    bit hit;
    @(negedge clk);
    bus_a.x = xb; bus_a.x_valid = v; bus_a.cfg_load = ld; bus_a.cfg_pattern = pat;
    bus_a.cfg_len = 4'(len); bus_a.cfg_overlap = ovl; bus_a.cnt_clr = clr;
    bus_b.x = xb; bus_b.x_valid = v; bus_b.cfg_load = ld; bus_b.cfg_pattern = pat;
    bus_b.cfg_len = 4'(len); bus_b.cfg_overlap = ovl; bus_b.cnt_clr = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = (len > 8) ? 8 : len;
      m_ovl = ovl;
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(xb);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      if (m_len > 0 && m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (CNT_EN) begin
      if (clr) begin
        m_ca = 0;
        m_cb = 0;
      end else if (hit) begin
        if (m_ca < 255) m_ca++;
        if (m_cb < 3) m_cb++;
      end
    end
    if (hit) exp_q.push_back({2'(m_cb), 8'(m_ca)});
  endtask

  task automatic samp(input bit b);
    step(b, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic samp_clr(input bit b);
    step(b, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ovl);
    step(1'b1, 1'b1, 1'b1, pat, len, ovl, 1'b0);
  endtask

  task automatic clr_cnt();
    step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
  endtask

  task automatic chk_counts(input string name);
    idle(1);
    @(posedge clk); #3;
    chk({name, "_cnt_a"}, int'(bus_a.match_count), m_ca);
    chk({name, "_cnt_b"}, int'(bus_b.match_count), m_cb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rst_y_a", int'(bus_a.y), 0);
    chk("rst_y_b", int'(bus_b.y), 0);
    chk("rst_cnt_a", int'(bus_a.match_count), 0);
    chk("rst_cnt_b", int'(bus_b.match_count), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [9:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("y_a_pulse", int'(bus_a.y), 1);
      chk("y_b_pulse", int'(bus_b.y), 1);
      chk("hit_cnt_a", int'(bus_a.match_count), int'(e[7:0]));
      chk("hit_cnt_b", int'(bus_b.match_count), int'(e[9:8]));
    end else begin
      chk("y_a_quiet", int'(bus_a.y), 0);
      chk("y_b_quiet", int'(bus_b.y), 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rp;
    int         rl;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_y", int'(bus_a.y), 0);
    chk("init_cnt", int'(bus_a.match_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // default 1010 overlapping detector
    samp(1); samp(0); samp(1); samp(0); samp(1); samp(0);
    idle(2);
    chk_counts("defaults");
    chk("defaults_two", int'(bus_a.match_count), CNT_EN ? 2 : 0);

    // non-overlapping 1010
    clr_cnt();
    load(8'b0000_1010, 4, 1'b0);
    samp(1); samp(0); samp(1); samp(0); samp(1); samp(0);
    chk_counts("nonovl");

    // gaps between samples
    load(8'b0000_1010, 4, 1'b1);
    samp(1); idle(1); samp(0); idle(2); samp(1); samp(0); idle(2);

    // reload mid-pattern, then length 0 and clamped length 15
    samp(1); samp(0); samp(1);
    load(8'b0000_0111, 3, 1'b1);
    for (int i = 0; i < 5; i++) samp(1);
    load(8'b0000_0000, 0, 1'b1);
    for (int i = 0; i < 10; i++) samp(0);
    load(8'hA5, 15, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      rp = 8'hA5;
      samp(rp[i]);
    end
    chk_counts("reload");

    // counter saturation and clear-over-hit
    clr_cnt();
    load(8'b0000_0011, 2, 1'b1);
    for (int i = 0; i < 8; i++) samp(1);
    chk_counts("sat");
    samp_clr(1);
    samp(1);
    chk_counts("clr_hit");

    // asynchronous reset mid-pattern
    load(8'b0000_1010, 4, 1'b1);
    samp(1); samp(0); samp(1);
    do_reset();
    samp(0);
    samp(1); samp(0); samp(1); samp(0);
    chk_counts("after_rst");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        rp = 8'($urandom());
        rl = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 4) : $urandom_range(0, 15);
        load(rp, rl, 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0, 8'h00, 0, 1'b0,
             $urandom_range(0, 99) == 0);
      end
    end
    chk_counts("random");

    idle(3);
    @(posedge clk); #3;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
